// File: rtl/room_thermal_model_pkg.sv
// Shared widths and heating/cooling mode encodings for the room thermal plant model.
package room_pkg;

  localparam int unsigned TEMP_W = 5;

  // Encoding matches the {heating, cooling} command pair.
  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_COOL = 2'b01,
    MODE_HEAT = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/room_thermal_model_temp_step_timer.sv
// Period counter: pulses tick_o when the count reaches last_i, then wraps.
// restart_i clears the count and suppresses the tick in the same cycle.
module temp_step_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = !restart_i && (cnt_q == last_i);

  // Next count: clear on restart or wrap, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/room_thermal_model.sv
// Room temperature plant model: ramps while heating/cooling, drifts toward
// ambient while idle, and flags a sticky fault on simultaneous commands.
module room_thermal_model #(
  parameter int unsigned TEMP_W       = room_pkg::TEMP_W,
  parameter int unsigned INIT_TEMP    = 20,
  parameter int unsigned T_MAX        = 31,
  parameter int unsigned HEAT_PERIOD  = 4,
  parameter int unsigned COOL_PERIOD  = 4,
  parameter int unsigned DRIFT_PERIOD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              heating,
  input  logic              cooling,
  input  logic [TEMP_W-1:0] ambient,
  input  logic              load,
  input  logic [TEMP_W-1:0] load_temp,
  output logic [TEMP_W-1:0] temperature,
  output logic              step,
  output logic              fault
);

  import room_pkg::*;

  localparam int unsigned MAX_P = max3(HEAT_PERIOD, COOL_PERIOD, DRIFT_PERIOD);
  localparam int unsigned CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0]  HEAT_LAST  = CNT_W'(HEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0]  COOL_LAST  = CNT_W'(COOL_PERIOD - 1);
  localparam logic [CNT_W-1:0]  DRIFT_LAST = CNT_W'(DRIFT_PERIOD - 1);
  localparam logic [TEMP_W-1:0] T_MAX_V    = TEMP_W'(T_MAX);
  localparam logic [TEMP_W-1:0] INIT_V     = TEMP_W'(INIT_TEMP);

  mode_e             mode_q, mode_in;
  logic [TEMP_W-1:0] temp_q, temp_nx, load_clamped;
  logic              step_q, fault_q;
  logic [CNT_W-1:0]  period_last;
  logic              restart, tick;

  assign mode_in      = mode_e'({heating, cooling});
  assign load_clamped = (load_temp > T_MAX_V) ? T_MAX_V : load_temp;

  // BOTH keeps the counter parked at zero, so no tick can ever fire in it.
  assign restart = load || (mode_in != mode_q) || (mode_q == MODE_BOTH);

  // Period selection for the currently latched mode.
  always_comb begin
    period_last = '0;
    unique case (mode_q)
      MODE_HEAT: period_last = HEAT_LAST;
      MODE_COOL: period_last = COOL_LAST;
      MODE_IDLE: period_last = DRIFT_LAST;
      default:   period_last = '0;
    endcase
  end

  temp_step_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .restart_i(restart),
    .last_i   (period_last),
    .tick_o   (tick)
  );

  // Candidate temperature for a period tick, saturating at 0 and T_MAX.
  always_comb begin
    temp_nx = temp_q;
    unique case (mode_q)
      MODE_HEAT: if (temp_q < T_MAX_V) temp_nx = temp_q + 1'b1;
      MODE_COOL: if (temp_q != '0) temp_nx = temp_q - 1'b1;
      MODE_IDLE: begin
        if ((temp_q < ambient) && (temp_q < T_MAX_V)) temp_nx = temp_q + 1'b1;
        else if (temp_q > ambient)                   temp_nx = temp_q - 1'b1;
      end
      default:   temp_nx = temp_q;
    endcase
  end

  // Mode, temperature, step pulse and sticky fault, prioritised load > mode change > tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_IDLE;
      temp_q  <= INIT_V;
      step_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (load) begin
        temp_q  <= load_clamped;
        mode_q  <= mode_in;
        fault_q <= 1'b0;
      end else begin
        if (mode_in == MODE_BOTH) begin
          fault_q <= 1'b1;
        end
        if (mode_in != mode_q) begin
          mode_q <= mode_in;
        end else if (tick) begin
          temp_q <= temp_nx;
          step_q <= (temp_nx != temp_q);
        end
      end
    end
  end

  assign temperature = temp_q;
  assign step        = step_q;
  assign fault       = fault_q;

endmodule
